// File: rtl/alu_pkg.sv
// Shared ALU-side definitions: word geometry, the one's-complement minus-zero
// encoding and the odd-parity helper used by both the packer and the checker.
package alu_pkg;
  localparam int WORD_W = 16;
  localparam int DATA_W = 15;
  localparam int ADDR_W = 12;

  localparam logic [DATA_W-1:0] NEG_ZERO = 15'h7FFF;

  typedef enum logic {IDLE, WRITE} wb_state_t;

  // Parity bit that makes {d, p} carry an odd number of ones.
  function automatic logic odd_parity(input logic [DATA_W-1:0] d);
    return ~^d;
  endfunction
endpackage

// File: rtl/word_fifo.sv
// Synchronous DEPTH x W FIFO with show-ahead head word and occupancy count.
module word_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          empty
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;

  assign rdata = mem[rd_ptr];
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_wb_packer.sv
// Packs one's-complement ALU results into parity-protected words, queues them
// and streams them to memory at an auto-incrementing address.
module alu_wb_packer
  import alu_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter bit NORM_NEG_ZERO = 1'b0,
  localparam int CW           = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] res_in,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              addr_load,
  output logic [WORD_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [CW-1:0]     fifo_count,
  output logic              busy
);
  wb_state_t         state;
  logic [DATA_W-1:0] d;
  logic [WORD_W-1:0] enc;
  logic [WORD_W-1:0] head;
  logic              push;
  logic              pop;
  logic              empty;

  assign d   = (NORM_NEG_ZERO && res_in == NEG_ZERO) ? '0 : res_in;
  assign enc = {d, odd_parity(d)};

  assign res_ready = (fifo_count < CW'(DEPTH));
  assign push      = res_valid & res_ready;
  // Pop feeds the output register: on leaving IDLE, or back-to-back on ack.
  assign pop       = ~empty & ((state == IDLE) | ((state == WRITE) & mem_ack));
  assign busy      = (fifo_count != '0) | mem_we;

  word_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (enc),
    .rdata (head),
    .count (fifo_count),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_addr  <= '0;
    end else begin
      if (addr_load && !busy) mem_addr <= base_addr;
      case (state)
        IDLE: begin
          if (!empty) begin
            state     <= WRITE;
            mem_we    <= 1'b1;
            mem_wdata <= head;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            if (!empty) begin
              mem_wdata <= head;
            end else begin
              state  <= IDLE;
              mem_we <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_wb_packer.sv
// Scoreboard bench: two packers (minus-zero kept / normalised) share stimulus;
// a negedge monitor pops expected words on every acknowledged write.
module tb_alu_wb_packer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [14:0] res_in;
  logic        res_valid;
  logic [11:0] base_addr;
  logic        addr_load;
  logic        mem_ack;

  logic        res_ready,  res_ready1;
  logic [15:0] mem_wdata,  mem_wdata1;
  logic [11:0] mem_addr,   mem_addr1;
  logic        mem_we,     mem_we1;
  logic [2:0]  fifo_count, fifo_count1;
  logic        busy,       busy1;

  typedef struct {
    logic [15:0] w0;
    logic [15:0] w1;
    logic [11:0] addr;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  logic [11:0] next_addr;

  always #5 clk = ~clk;

  alu_wb_packer #(.DEPTH(4), .NORM_NEG_ZERO(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .res_in(res_in), .res_valid(res_valid),
    .res_ready(res_ready), .base_addr(base_addr), .addr_load(addr_load),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_ack(mem_ack), .fifo_count(fifo_count), .busy(busy)
  );

  alu_wb_packer #(.DEPTH(4), .NORM_NEG_ZERO(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .res_in(res_in), .res_valid(res_valid),
    .res_ready(res_ready1), .base_addr(base_addr), .addr_load(addr_load),
    .mem_wdata(mem_wdata1), .mem_addr(mem_addr1), .mem_we(mem_we1),
    .mem_ack(mem_ack), .fifo_count(fifo_count1), .busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one result at posedge+1; queue its expectation only if it will be accepted.
  task automatic send(input logic [14:0] r, input logic [15:0] e0, input logic [15:0] e1,
                      output bit acc);
    res_in    = r;
    res_valid = 1'b1;
    #1;
    acc = res_ready;
    if (acc) begin
      sb.push_back('{w0: e0, w1: e1, addr: next_addr});
      next_addr = next_addr + 12'd1;
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_we"},     mem_we,     0);
    chk({tag, "_wdata"},  mem_wdata,  0);
    chk({tag, "_addr"},   mem_addr,   0);
    chk({tag, "_count"},  fifo_count, 0);
    chk({tag, "_ready"},  res_ready,  1);
    chk({tag, "_busy"},   busy,       0);
    chk({tag, "_ready1"}, res_ready1, 1);
    chk({tag, "_busy1"},  busy1,      0);
    chk({tag, "_cnt1"},   fifo_count1, 0);
  endtask

  // Monitor: pops on acknowledged writes, checks hold stability and DUT agreement.
  initial begin
    exp_t        e;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_w    = '0;
    logic [11:0] prev_a    = '0;
    forever begin
      @(negedge clk);
      if (rst_n) chk("we_match", mem_we1, mem_we);
      if (rst_n && mem_we) begin
        if (prev_hold) begin
          chk("hold_wdata", mem_wdata, prev_w);
          chk("hold_addr",  mem_addr,  prev_a);
        end
        if (mem_ack) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
          end else begin
            e = sb.pop_front();
            chk("wdata0", mem_wdata,  e.w0);
            chk("wdata1", mem_wdata1, e.w1);
            chk("addr0",  mem_addr,   e.addr);
            chk("addr1",  mem_addr1,  e.addr);
          end
        end
        prev_hold = !mem_ack;
        prev_w    = mem_wdata;
        prev_a    = mem_addr;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  typedef struct { logic [14:0] r; logic [15:0] e0; logic [15:0] e1; } vec_t;

  initial begin
    bit   acc;
    int   nacc;
    vec_t stream[6];
    vec_t bp[6];
    vec_t wrap[3];

    stream[0] = '{15'h7F66, 16'hFECC, 16'hFECC};
    stream[1] = '{15'h7FFF, 16'hFFFE, 16'h0001};
    stream[2] = '{15'h0000, 16'h0001, 16'h0001};
    stream[3] = '{15'h0001, 16'h0002, 16'h0002};
    stream[4] = '{15'h7FFE, 16'hFFFD, 16'hFFFD};
    stream[5] = '{15'h5555, 16'hAAAB, 16'hAAAB};

    bp[0] = '{15'h0001, 16'h0002, 16'h0002};
    bp[1] = '{15'h0003, 16'h0007, 16'h0007};
    bp[2] = '{15'h0007, 16'h000E, 16'h000E};
    bp[3] = '{15'h000F, 16'h001F, 16'h001F};
    bp[4] = '{15'h001F, 16'h003E, 16'h003E};
    bp[5] = '{15'h003F, 16'h007F, 16'h007F};

    wrap[0] = '{15'h0100, 16'h0200, 16'h0200};
    wrap[1] = '{15'h0300, 16'h0601, 16'h0601};
    wrap[2] = '{15'h7000, 16'hE000, 16'hE000};

    rst_n = 1'b0; res_in = '0; res_valid = 1'b0;
    base_addr = '0; addr_load = 1'b0; mem_ack = 1'b0;
    next_addr = '0;
    cycles(2);
    chk_reset_state("rst");

    // Release, then load base and accept on the very first edge.
    rst_n = 1'b1;
    mem_ack = 1'b1;
    base_addr = 12'h100; addr_load = 1'b1;
    next_addr = 12'h100;
    send(15'h0099, 16'h0133, 16'h0133, acc);
    addr_load = 1'b0;
    chk("first_edge_acc", acc, 1);
    chk("lat_n_we", mem_we, 0);
    chk("lat_n_count", fifo_count, 1);
    chk("lat_n_addr", mem_addr, 12'h100);
    cycles(1);
    chk("lat_n1_we", mem_we, 1);
    chk("lat_n1_wdata", mem_wdata, 16'h0133);
    cycles(3);

    // Back-to-back stream with mem_ack held high.
    foreach (stream[i]) send(stream[i].r, stream[i].e0, stream[i].e1, acc);
    cycles(4);
    chk("stream_idle_busy", busy, 0);
    chk("stream_drained", sb.size(), 0);

    // Backpressure: hold ack low, 6 attempts; 5 fit (4 queued + output register).
    mem_ack = 1'b0;
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      send(bp[i].r, bp[i].e0, bp[i].e1, acc);
      if (acc) nacc++;
      if (i == 4) begin
        chk("full_ready", res_ready, 0);
        chk("full_count", fifo_count, 4);
      end
    end
    chk("bp_accepted", nacc, 5);
    chk("bp_drop_count", fifo_count, 4);
    // Address load while busy must be ignored.
    base_addr = 12'h555; addr_load = 1'b1;
    cycles(1);
    addr_load = 1'b0;
    mem_ack = 1'b1;
    cycles(5);
    chk("bp_no_bubble_we", mem_we, 0);
    chk("bp_drained", sb.size(), 0);

    // Address wrap from FFE.
    base_addr = 12'hFFE; addr_load = 1'b1;
    cycles(1);
    addr_load = 1'b0;
    next_addr = 12'hFFE;
    chk("load_addr", mem_addr, 12'hFFE);
    foreach (wrap[i]) send(wrap[i].r, wrap[i].e0, wrap[i].e1, acc);
    cycles(4);
    chk("wrap_addr_after", mem_addr, 12'h001);
    chk("wrap_drained", sb.size(), 0);

    // Reset in the middle of a pending write with two entries queued.
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) send(bp[i].r, bp[i].e0, bp[i].e1, acc);
    chk("pre_rst_we", mem_we, 1);
    chk("pre_rst_count", fifo_count, 2);
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    sb.delete();
    next_addr = '0;
    mem_ack = 1'b1;
    cycles(1);
    rst_n = 1'b1;
    cycles(5);
    chk("post_rst_we", mem_we, 0);
    chk("post_rst_busy", busy, 0);

    chk("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
